fp32_iterative_divider: RTL and testbench
=========================================

Name: fp32_iterative_divider

Overview:
- Sequential IEEE-754 single-precision divider (resultDiv = A / B), the inverse operation of the FPU's combinational multiplier.
- Same operand format, round_mode encoding and error/overflow flag semantics as the multiplier, so the FPU top can mux results from either unit.
- Restoring radix-2 mantissa division; a start/busy/done handshake replaces the multiplier's single-cycle combinational path.

Parameters:
- ITER_PER_CYCLE, 1, quotient bits produced per clock; legal values 1, 3, 9. Normal-path latency = 27/ITER_PER_CYCLE + 2 cycles.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  32  dividend, IEEE-754 single
- B  input  32  divisor, IEEE-754 single
- round_mode  input  2  11 toward zero, 10 nearest-even, 00 toward +inf, 01 toward -inf
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result and flags are valid
- errorDiv  output  1  invalid operation, divide-by-zero, or overflow
- overflowDiv  output  1  exponent overflow
- resultDiv  output  32  quotient, held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE; busy, done, errorDiv, overflowDiv = 0; resultDiv = 0.
- Reset mid-operation: abandons the operation. No done pulse. Outputs take reset values on the next edge.
- States: IDLE, DIVIDE, ROUND, DONE.
- IDLE:
  - start=1 latches A, B and round_mode (cycle 0); busy rises in cycle 1.
  - If a special case applies, go to DONE with the result registered. Otherwise go to DIVIDE.
- Special cases. Decode order: NaN, then inf, then zero. E=0 inputs are treated as zero (flush-to-zero). S = A[31]^B[31].
  - Either input NaN: 0x7FC00000, errorDiv=1.
  - inf/inf or 0/0: 0x7FC00000, errorDiv=1.
  - inf/finite: {S,FF,0}, flags 0.
  - finite/inf: {S,00,0}, flags 0.
  - nonzero/0: {S,FF,0}, errorDiv=1, overflowDiv=0.
  - 0/nonzero: {S,00,0}, flags 0.
  - Special-case done is asserted in cycle 1.
- DIVIDE:
  - Computes q = floor(M1*2^26 / M2), where M = {1,F}. q is 27 bits; rem is the final remainder.
  - ITER_PER_CYCLE bits per cycle, MSB first; 27/ITER_PER_CYCLE cycles.
  - Exponent uses a 10-bit signed value: e = E1 - E2 + 127.
- ROUND (one cycle):
  - If q[26]: mant = q[26:3], guard = q[2], sticky = |q[1:0] | (rem!=0).
  - Else: mant = q[25:2], guard = q[1], sticky = q[0] | (rem!=0), and e = e - 1.
  - Increment rule:
    - RNE: guard & (sticky | mant[0]).
    - +inf: !S & (guard|sticky).
    - -inf: S & (guard|sticky).
    - RTZ: never.
  - A carry out of mant sets mant = 0x800000 and e = e + 1.
- Final result:
  - e >= 255: overflowDiv=1, errorDiv=1. Result is {S,FF,0}, except for rounding modes that round toward zero for sign S, which give {S,FE,7FFFFF}.
  - e <= 0: {S,00,0}, flags 0.
  - Otherwise: {S, e[7:0], mant[22:0]}.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start presented in DONE is ignored. start is accepted again from the following IDLE cycle.
- Normal-path done falls in cycle 27/ITER_PER_CYCLE + 2 (cycle 29 for ITER_PER_CYCLE=1).
- start while busy: ignored; latched operands are unaffected.

Optional Feature:
- Macro: FP32_DIV_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort=1 while busy returns the block to IDLE on the next edge. No done pulse; resultDiv and flags keep their previous values.
  - abort outside busy has no effect. reset has priority over abort.
- Undefined: no abort port; behaviour is exactly as above.

Decomposition:
- Shared package fpu_pkg:
  - round-mode constants RM_RTZ=2'b11, RM_RNE=2'b10, RM_PINF=2'b00, RM_NINF=2'b01
  - QNAN=32'h7FC00000, EXP_BIAS=127, EXP_MAX=8'hFF
  - divider state enum
  - fp_class_t (zero, normal, inf, nan)
- One natural sub-module: fp32_round. Combinational; inputs sign, mant, guard, sticky, exponent, round_mode. Reusable later by the multiplier.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> resultDiv=0x40400000, flags 0, done in cycle 29, busy high in cycles 1-28.
- 0x3F800000 / 0x40400000: RNE -> 0x3EAAAAAB, RTZ -> 0x3EAAAAAA, +inf -> 0x3EAAAAAB, -inf -> 0x3EAAAAAA. 0xBF800000 / 0x40400000 with -inf -> 0xBEAAAAAB.
- 0x3F800000 / 0x00000000 -> 0x7F800000 with errorDiv=1, overflowDiv=0. 0/0 -> 0x7FC00000 with errorDiv=1. Both have done in cycle 1.
- 0x7F000000 / 0x3F000000 with RNE -> 0x7F800000, overflowDiv=1, errorDiv=1; with RTZ -> 0x7F7FFFFF. 0x00800000 / 0x40000000 -> 0x00000000, flags 0.
- start pulsed in cycle 5 with new operands -> ignored; first result is unchanged.
- reset asserted in cycle 10 -> busy=0 and resultDiv=0 from cycle 11, no done.
- With FP32_DIV_ABORT_EN: abort in cycle 8 -> IDLE, no done, prior result retained.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, special constants,
// operand classification and the iterative divider state type.
package fpu_pkg;

  localparam logic [1:0]  RM_RTZ   = 2'b11;
  localparam logic [1:0]  RM_RNE   = 2'b10;
  localparam logic [1:0]  RM_PINF  = 2'b00;
  localparam logic [1:0]  RM_NINF  = 2'b01;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ROUND,
    ST_DONE
  } div_state_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Denormals (E=0) are flushed to zero.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    if (x[30:23] == 8'h00)         return FP_ZERO;
    else if (x[30:23] != EXP_MAX)  return FP_NORMAL;
    else if (x[22:0] == 23'h0)     return FP_INF;
    else                           return FP_NAN;
  endfunction

endpackage

// File: rtl/fp32_round.sv
// Rounds a normalised 24-bit mantissa with guard/sticky and packs the final
// single-precision result, saturating on exponent overflow or underflow.
module fp32_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic [23:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic signed [9:0] exponent,
  input  logic [1:0]        round_mode,
  output logic [31:0]       result,
  output logic              overflow
);

  logic              incr;
  logic              to_zero;
  logic [24:0]       sum;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_r;

  always_comb begin
    incr     = 1'b0;
    to_zero  = 1'b0;
    overflow = 1'b0;
    result   = '0;

    case (round_mode)
      RM_RNE:  incr = guard & (sticky | mant[0]);
      RM_PINF: incr = ~sign & (guard | sticky);
      RM_NINF: incr = sign & (guard | sticky);
      default: incr = 1'b0;
    endcase

    sum = {1'b0, mant} + {24'h0, incr};
    if (sum[24]) begin
      mant_r = 24'h800000;
      exp_r  = exponent + 10'sd1;
    end else begin
      mant_r = sum[23:0];
      exp_r  = exponent;
    end

    // Modes that round toward zero for this sign saturate to max finite.
    to_zero = (round_mode == RM_RTZ) ||
              (round_mode == RM_PINF && sign) ||
              (round_mode == RM_NINF && !sign);

    if (exp_r >= 10'sd255) begin
      overflow = 1'b1;
      result   = to_zero ? {sign, 8'hFE, 23'h7FFFFF} : {sign, EXP_MAX, 23'h0};
    end else if (exp_r <= 10'sd0) begin
      result   = {sign, 31'h0};
    end else begin
      result   = {sign, exp_r[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fp32_iterative_divider.sv
// Sequential IEEE-754 single-precision divider (restoring radix-2).
// Define FP32_DIV_ABORT_EN to add the abort input.
module fp32_iterative_divider
  import fpu_pkg::*;
#(
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef FP32_DIV_ABORT_EN
  input  logic        abort,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        busy,
  output logic        done,
  output logic        errorDiv,
  output logic        overflowDiv,
  output logic [31:0] resultDiv
);

  localparam int unsigned DIV_CYCLES = 27 / ITER_PER_CYCLE;

  div_state_t        state_q, state_d;
  logic              sign_q, sign_d;
  logic [1:0]        rm_q, rm_d;
  logic [23:0]       m2_q, m2_d;
  logic [25:0]       rem_q, rem_d;
  logic [26:0]       quot_q, quot_d;
  logic signed [9:0] exp_q, exp_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  fp_class_t         cls_a, cls_b;
  logic              sign_in;
  logic              abort_req;
  logic [25:0]       div_rem;
  logic [26:0]       div_quot;
  logic              qbit;
  logic [23:0]       rnd_mant;
  logic              rnd_guard, rnd_sticky;
  logic signed [9:0] rnd_exp;
  logic [31:0]       rnd_result;
  logic              rnd_ovf;

`ifdef FP32_DIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign cls_a   = fp_classify(A);
  assign cls_b   = fp_classify(B);
  assign sign_in = A[31] ^ B[31];

  // Partial remainder is kept pre-shifted for the next bit, so the final
  // value is twice the true remainder; only its zero-ness is used.
  always_comb begin
    div_rem  = rem_q;
    div_quot = quot_q;
    qbit     = 1'b0;
    for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
      qbit     = (div_rem >= {2'b00, m2_q});
      if (qbit) div_rem = div_rem - {2'b00, m2_q};
      div_rem  = div_rem << 1;
      div_quot = {div_quot[25:0], qbit};
    end
  end

  always_comb begin
    if (quot_q[26]) begin
      rnd_mant   = quot_q[26:3];
      rnd_guard  = quot_q[2];
      rnd_sticky = (|quot_q[1:0]) | (rem_q != '0);
      rnd_exp    = exp_q;
    end else begin
      rnd_mant   = quot_q[25:2];
      rnd_guard  = quot_q[1];
      rnd_sticky = quot_q[0] | (rem_q != '0);
      rnd_exp    = exp_q - 10'sd1;
    end
  end

  fp32_round u_round (
    .sign       (sign_q),
    .mant       (rnd_mant),
    .guard      (rnd_guard),
    .sticky     (rnd_sticky),
    .exponent   (rnd_exp),
    .round_mode (rm_q),
    .result     (rnd_result),
    .overflow   (rnd_ovf)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    rm_d     = rm_q;
    m2_d     = m2_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          rm_d    = round_mode;
          m2_d    = {1'b1, B[22:0]};
          rem_d   = {2'b01, A[22:0]};
          quot_d  = '0;
          exp_d   = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]})
                    + 10'(EXP_BIAS);
          cnt_d   = 5'(DIV_CYCLES - 1);
          state_d = ST_DONE;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            result_d = QNAN;
            err_d    = 1'b1;
          end else if (cls_a == FP_INF) begin
            result_d = (cls_b == FP_INF) ? QNAN : {sign_in, EXP_MAX, 23'h0};
            err_d    = (cls_b == FP_INF);
          end else if (cls_b == FP_INF) begin
            result_d = {sign_in, 31'h0};
          end else if (cls_a == FP_ZERO) begin
            result_d = (cls_b == FP_ZERO) ? QNAN : {sign_in, 31'h0};
            err_d    = (cls_b == FP_ZERO);
          end else if (cls_b == FP_ZERO) begin
            result_d = {sign_in, EXP_MAX, 23'h0};
            err_d    = 1'b1;
          end else begin
            state_d  = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        rem_d  = div_rem;
        quot_d = div_quot;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == '0) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        err_d    = rnd_ovf;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the operation before any result/flag update commits.
    if (abort_req && (state_q == ST_DIVIDE || state_q == ST_ROUND)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      rm_q     <= '0;
      m2_q     <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      rm_q     <= rm_d;
      m2_q     <= m2_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy        = (state_q == ST_DIVIDE) || (state_q == ST_ROUND);
  assign done        = (state_q == ST_DONE);
  assign resultDiv   = result_q;
  assign errorDiv    = err_q;
  assign overflowDiv = ovf_q;

endmodule

// File: tb/tb_fp32_iterative_divider.sv
// Directed bench for fp32_iterative_divider (ITER_PER_CYCLE = 1).
module tb_fp32_iterative_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
`ifdef FP32_DIV_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  round_mode = 2'b10;
  logic        busy, done, errorDiv, overflowDiv;
  logic [31:0] resultDiv;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fp32_iterative_divider #(.ITER_PER_CYCLE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef FP32_DIV_ABORT_EN
    .abort       (abort),
`endif
    .A           (A),
    .B           (B),
    .round_mode  (round_mode),
    .busy        (busy),
    .done        (done),
    .errorDiv    (errorDiv),
    .overflowDiv (overflowDiv),
    .resultDiv   (resultDiv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; presents the request in cycle 0 and returns at the
  // negedge of the done cycle (or after a bounded wait).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        output int cyc, output logic busy_ok);
    A = a; B = b; round_mode = rm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] exp_res,
                        input logic exp_err, input logic exp_ovf, input int exp_cyc);
    int   cyc;
    logic bok;
    run_op(a, b, rm, cyc, bok);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_res"}, resultDiv, exp_res);
    chk({tag, "_err"}, {31'h0, errorDiv}, {31'h0, exp_err});
    chk({tag, "_ovf"}, {31'h0, overflowDiv}, {31'h0, exp_ovf});
    @(negedge clk);
  endtask

  initial begin
    int   cyc;
    int   done_seen;
    logic bok;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, errorDiv}, 32'h0);
    chk("rst_ovf", {31'h0, overflowDiv}, 32'h0);
    chk("rst_res", resultDiv, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 6 / 2 with full timing profile, then a start presented in DONE
    run_op(32'h40C00000, 32'h40000000, 2'b10, cyc, bok);
    chk("six_cycle", 32'(cyc), 32'd29);
    chk("six_busy_window", {31'h0, bok}, 32'h1);
    chk("six_busy_at_done", {31'h0, busy}, 32'h0);
    chk("six_res", resultDiv, 32'h40400000);
    chk("six_flags", {30'h0, errorDiv, overflowDiv}, 32'h0);
    A = 32'h3F800000; B = 32'h00000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("idle_after_done", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("start_in_done_ignored", {31'h0, done}, 32'h0);
    chk("start_in_done_res", resultDiv, 32'h40400000);

    // 1 / 3 in every rounding mode, plus -1/3 toward -inf
    op_chk("third_rne",  32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
    op_chk("third_rtz",  32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 1'b0, 1'b0, 29);
    op_chk("third_pinf", 32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
    op_chk("third_ninf", 32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 1'b0, 1'b0, 29);
    op_chk("mthird_ninf", 32'hBF800000, 32'h40400000, 2'b01, 32'hBEAAAAAB, 1'b0, 1'b0, 29);

    // Special cases finish in cycle 1
    op_chk("div_by_zero", 32'h3F800000, 32'h00000000, 2'b10, 32'h7F800000, 1'b1, 1'b0, 1);
    op_chk("zero_by_zero", 32'h00000000, 32'h00000000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 1);
    op_chk("nan_in", 32'h7FC00001, 32'h3F800000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 1);
    op_chk("inf_by_inf", 32'h7F800000, 32'hFF800000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 1);
    op_chk("ninf_by_fin", 32'hFF800000, 32'h40000000, 2'b10, 32'hFF800000, 1'b0, 1'b0, 1);
    op_chk("fin_by_inf", 32'h40000000, 32'h7F800000, 2'b10, 32'h00000000, 1'b0, 1'b0, 1);
    op_chk("zero_by_fin", 32'h80000000, 32'h40000000, 2'b10, 32'h80000000, 1'b0, 1'b0, 1);

    // Exponent boundaries
    op_chk("ovf_rne", 32'h7F000000, 32'h3F000000, 2'b10, 32'h7F800000, 1'b1, 1'b1, 29);
    op_chk("ovf_rtz", 32'h7F000000, 32'h3F000000, 2'b11, 32'h7F7FFFFF, 1'b1, 1'b1, 29);
    op_chk("unf", 32'h00800000, 32'h40000000, 2'b10, 32'h00000000, 1'b0, 1'b0, 29);

    // start while busy is ignored
    A = 32'h3F800000; B = 32'h40400000; round_mode = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 5) begin
        A = 32'h40C00000; B = 32'h40000000; round_mode = 2'b11; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("busy_start_cycle", 32'(cyc), 32'd29);
    chk("busy_start_res", resultDiv, 32'h3EAAAAAB);
    @(negedge clk);

    // reset in cycle 10 abandons the operation
    A = 32'h40C00000; B = 32'h40000000; round_mode = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_res", resultDiv, 32'h0);
    done_seen = 0;
    repeat (30) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(done_seen), 32'h0);

`ifdef FP32_DIV_ABORT_EN
    op_chk("pre_abort", 32'h40C00000, 32'h40000000, 2'b10, 32'h40400000, 1'b0, 1'b0, 29);
    A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    done_seen = 0;
    repeat (30) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(done_seen), 32'h0);
    chk("abort_res_kept", resultDiv, 32'h40400000);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
